// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// It also handles the memory-ready wait, stall, traps and the retired-instruction count.
module multicycle_control_unit #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   input  logic               stall,
   output logic [2:0]         state,
   output logic               pcWrite,
   output logic               irWrite,
   output logic               iorD,
   output logic               memRead,
   output logic               memWrite,
   output logic               regWrite,
   output logic               regDst,
   output logic               ALUsrc,
   output logic [ALUOP_W-1:0] ALUop,
   output logic               byteOperations,
   output logic               link,
   output logic               illegal,
   output logic               bus_error,
   output logic [CNT_W-1:0]   retired
);
   // state  | meaning
   // FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
   // DECODE | latch opcode class, trap if illegal
   // EXEC   | ALU op; branches and jumps finish here
   // MEM    | load/store access at ALUout, wait for mem_ready
   // WB     | register file write
   // TRAP   | dead until reset
   typedef enum logic [2:0] {
      S_FETCH = 3'b000, S_DECODE = 3'b001, S_EXEC = 3'b010,
      S_MEM   = 3'b011, S_WB     = 3'b100, S_TRAP = 3'b101
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_ADDI, C_SUBI, C_ANDI, C_ORI, C_SLTI, C_LW, C_LB,
      C_SW, C_SB, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
   } cls_t;

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   function automatic cls_t decode_op(input logic [5:0] op);
      case (op)
         6'b000000: decode_op = C_R;
         6'b000010: decode_op = C_ADDI;
         6'b000011: decode_op = C_SUBI;
         6'b000100: decode_op = C_ANDI;
         6'b000101: decode_op = C_ORI;
         6'b000111: decode_op = C_SLTI;
         6'b001000: decode_op = C_LW;
         6'b001001: decode_op = C_LB;
         6'b010000: decode_op = C_SW;
         6'b010001: decode_op = C_SB;
         6'b100011: decode_op = C_BEQ;
         6'b100111: decode_op = C_BNE;
         6'b111000: decode_op = C_J;
         6'b111001: decode_op = C_JAL;
         default:   decode_op = C_ILL;
      endcase
   endfunction

   state_t        state_q, state_nx;
   cls_t          cls_q, cls_dec;
   logic [TW-1:0] tmo_q;
   logic          wait_fail, retire, trap_ill, trap_bus;
   logic          is_imm, is_mem, is_load, is_store, is_byte;
   logic [2:0]    alu_cls, alu3;

   assign state    = state_q;
   assign cls_dec  = decode_op(opcode);
   assign is_imm   = (cls_q == C_ADDI) || (cls_q == C_SUBI) || (cls_q == C_ANDI) ||
                     (cls_q == C_ORI)  || (cls_q == C_SLTI);
   assign is_load  = (cls_q == C_LW) || (cls_q == C_LB);
   assign is_store = (cls_q == C_SW) || (cls_q == C_SB);
   assign is_mem   = is_load || is_store;
   assign is_byte  = (cls_q == C_LB) || (cls_q == C_SB);
   // The access fails on the cycle the wait count would reach MEM_TIMEOUT.
   assign wait_fail = !mem_ready && (tmo_q == TW'(MEM_TIMEOUT - 1));

   always_comb begin
      case (cls_q)
         C_R:                  alu_cls = 3'b111;
         C_SUBI, C_BEQ, C_BNE: alu_cls = 3'b001;
         C_ANDI:               alu_cls = 3'b010;
         C_ORI:                alu_cls = 3'b011;
         C_SLTI:               alu_cls = 3'b100;
         default:              alu_cls = 3'b000;
      endcase
   end

   always_comb begin
      state_nx = state_q;
      retire   = 1'b0;
      trap_ill = 1'b0;
      trap_bus = 1'b0;
      if (!stall) begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) state_nx = S_DECODE;
               else if (wait_fail) begin
                  state_nx = S_TRAP;
                  trap_bus = 1'b1;
               end
            end
            S_DECODE: begin
               if (cls_dec == C_ILL) begin
                  state_nx = S_TRAP;
                  trap_ill = 1'b1;
               end else state_nx = S_EXEC;
            end
            S_EXEC: begin
               if (cls_q == C_R || is_imm) state_nx = S_WB;
               else if (is_mem)            state_nx = S_MEM;
               else begin
                  state_nx = S_FETCH;
                  retire   = 1'b1;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (is_load) state_nx = S_WB;
                  else begin
                     state_nx = S_FETCH;
                     retire   = 1'b1;
                  end
               end else if (wait_fail) begin
                  state_nx = S_TRAP;
                  trap_bus = 1'b1;
               end
            end
            S_WB: begin
               state_nx = S_FETCH;
               retire   = 1'b1;
            end
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_FETCH;
         endcase
      end
   end

   always_comb begin
      pcWrite        = 1'b0;
      irWrite        = 1'b0;
      iorD           = 1'b0;
      memRead        = 1'b0;
      memWrite       = 1'b0;
      regWrite       = 1'b0;
      regDst         = 1'b0;
      ALUsrc         = 1'b0;
      byteOperations = 1'b0;
      link           = 1'b0;
      alu3           = 3'b000;
      case (state_q)
         S_FETCH: begin
            memRead = 1'b1;
            pcWrite = mem_ready;
            irWrite = mem_ready;
         end
         S_EXEC: begin
            ALUsrc = is_imm || is_mem;
            alu3   = alu_cls;
            case (cls_q)
               C_BEQ: pcWrite = zero;
               C_BNE: pcWrite = !zero;
               C_J:   pcWrite = 1'b1;
               C_JAL: begin
                  pcWrite  = 1'b1;
                  regWrite = 1'b1;
                  link     = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            iorD           = 1'b1;
            ALUsrc         = 1'b1;
            memRead        = is_load;
            memWrite       = is_store;
            byteOperations = is_byte;
         end
         S_WB: begin
            regWrite       = 1'b1;
            regDst         = (cls_q == C_R);
            ALUsrc         = is_imm || is_mem;
            alu3           = alu_cls;
            byteOperations = (cls_q == C_LB);
         end
         default: ;
      endcase
      // Write/request strobes are suppressed while stalled and while reset is held.
      if (stall || !rst_n) begin
         pcWrite  = 1'b0;
         irWrite  = 1'b0;
         regWrite = 1'b0;
         memRead  = 1'b0;
         memWrite = 1'b0;
      end
      if (!rst_n) begin
         iorD           = 1'b0;
         regDst         = 1'b0;
         ALUsrc         = 1'b0;
         byteOperations = 1'b0;
         link           = 1'b0;
         alu3           = 3'b000;
      end
      ALUop       = '0;
      ALUop[2:0]  = alu3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cls_q     <= C_R;
         tmo_q     <= '0;
         illegal   <= 1'b0;
         bus_error <= 1'b0;
         retired   <= '0;
      end else if (!stall) begin
         state_q <= state_nx;
         if (state_q == S_DECODE) cls_q <= cls_dec;
         if (trap_ill) illegal   <= 1'b1;
         if (trap_bus) bus_error <= 1'b1;
         if (retire)   retired   <= retired + CNT_W'(1);
         if ((state_nx != state_q) && (state_nx == S_FETCH || state_nx == S_MEM))
            tmo_q <= '0;
         else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
            tmo_q <= tmo_q + TW'(1);
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver queues hand-computed
// per-cycle output snapshots, and a negedge monitor pops and compares them.
module tb_multicycle_control_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero, mem_ready, stall;
   logic [2:0] state, ALUop, retired;
   logic       pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst;
   logic       ALUsrc, byteOperations, link, illegal, bus_error;

   multicycle_control_unit #(.ALUOP_W(3), .MEM_TIMEOUT(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .stall(stall), .state(state), .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD),
      .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst),
      .ALUsrc(ALUsrc), .ALUop(ALUop), .byteOperations(byteOperations), .link(link),
      .illegal(illegal), .bus_error(bus_error), .retired(retired)
   );

   always #5 clk = ~clk;

   localparam logic [9:0] NONE = 10'b0000000000;
   localparam logic [9:0] PCW  = 10'b1000000000;
   localparam logic [9:0] IRW  = 10'b0100000000;
   localparam logic [9:0] IORD = 10'b0010000000;
   localparam logic [9:0] MRD  = 10'b0001000000;
   localparam logic [9:0] MWR  = 10'b0000100000;
   localparam logic [9:0] RGW  = 10'b0000010000;
   localparam logic [9:0] RDST = 10'b0000001000;
   localparam logic [9:0] ASRC = 10'b0000000100;
   localparam logic [9:0] BYTE = 10'b0000000010;
   localparam logic [9:0] LNK  = 10'b0000000001;

   localparam logic [2:0] SF = 3'b000, SD = 3'b001, SE = 3'b010, SM = 3'b011, SW = 3'b100, ST = 3'b101;
   localparam logic L = 1'b0, H = 1'b1;

   localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b000010, OP_LW = 6'b001000;
   localparam logic [5:0] OP_SW = 6'b010000, OP_SB = 6'b010001, OP_BEQ = 6'b100011;
   localparam logic [5:0] OP_BNE = 6'b100111, OP_J = 6'b111000, OP_JAL = 6'b111001;
   localparam logic [5:0] OP_BAD = 6'b111111;

   typedef struct packed {
      logic [15:0] id;
      logic [2:0]  st;
      logic [9:0]  stb;
      logic [2:0]  aop;
      logic [2:0]  ret;
      logic        ill;
      logic        bus;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   id_n   = 0;

   task automatic push(input logic [2:0] es, input logic [9:0] eb, input logic [2:0] ea,
                       input logic [2:0] er, input logic ei, input logic ebus);
      exp_t e;
      e.id  = 16'(id_n);
      e.st  = es;
      e.stb = eb;
      e.aop = ea;
      e.ret = er;
      e.ill = ei;
      e.bus = ebus;
      exp_q.push_back(e);
      id_n++;
   endtask

   // Drives one cycle's inputs just after a rising edge; the monitor checks at the falling edge.
   task automatic step(input logic [5:0] op, input logic z, input logic mr, input logic st_in,
                       input logic [2:0] es, input logic [9:0] eb, input logic [2:0] ea,
                       input logic [2:0] er, input logic ei, input logic ebus);
      opcode    = op;
      zero      = z;
      mem_ready = mr;
      stall     = st_in;
      push(es, eb, ea, er, ei, ebus);
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between clock edges, so the reset state must appear asynchronously.
   task automatic reset_pulse();
      stall     = H;
      mem_ready = L;
      rst_n     = L;
      push(SF, NONE, 3'b000, 3'd0, L, L);
      @(negedge clk);
      #1;
      rst_n = H;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [9:0] stb;
         e   = exp_q.pop_front();
         stb = {pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, ALUsrc,
                byteOperations, link};
         checks++;
         if (state !== e.st || stb !== e.stb || ALUop !== e.aop || retired !== e.ret ||
             illegal !== e.ill || bus_error !== e.bus) begin
            errors++;
            $display("FAIL cyc%0d: got state=%b strobes=%b aluop=%b retired=%0d illegal=%b bus_error=%b, expected state=%b strobes=%b aluop=%b retired=%0d illegal=%b bus_error=%b",
                     e.id, state, stb, ALUop, retired, illegal, bus_error,
                     e.st, e.stb, e.aop, e.ret, e.ill, e.bus);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      opcode = OP_ADDI;
      zero = L;
      reset_pulse();

      // addi; the opcode changes during EXEC but the latched class still goes to WB
      step(OP_ADDI, L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd0, L, L);
      step(OP_ADDI, L, H, L, SD, NONE,        3'b000, 3'd0, L, L);
      step(OP_SW,   L, H, L, SE, ASRC,        3'b000, 3'd0, L, L);
      step(OP_SW,   L, H, L, SW, RGW|ASRC,    3'b000, 3'd0, L, L);
      // lw with three not-ready MEM cycles; ready on the fourth beats the timeout
      step(OP_LW, L, H, L, SF, PCW|IRW|MRD,   3'b000, 3'd1, L, L);
      step(OP_LW, L, H, L, SD, NONE,          3'b000, 3'd1, L, L);
      step(OP_LW, L, H, L, SE, ASRC,          3'b000, 3'd1, L, L);
      step(OP_LW, L, L, L, SM, IORD|MRD|ASRC, 3'b000, 3'd1, L, L);
      step(OP_LW, L, L, L, SM, IORD|MRD|ASRC, 3'b000, 3'd1, L, L);
      step(OP_LW, L, L, L, SM, IORD|MRD|ASRC, 3'b000, 3'd1, L, L);
      step(OP_LW, L, H, L, SM, IORD|MRD|ASRC, 3'b000, 3'd1, L, L);
      step(OP_LW, L, H, L, SW, RGW|ASRC,      3'b000, 3'd1, L, L);
      // sb
      step(OP_SB, L, H, L, SF, PCW|IRW|MRD,        3'b000, 3'd2, L, L);
      step(OP_SB, L, H, L, SD, NONE,               3'b000, 3'd2, L, L);
      step(OP_SB, L, H, L, SE, ASRC,               3'b000, 3'd2, L, L);
      step(OP_SB, L, H, L, SM, IORD|MWR|ASRC|BYTE, 3'b000, 3'd2, L, L);
      // beq taken, beq not taken, bne taken
      step(OP_BEQ, H, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd3, L, L);
      step(OP_BEQ, H, H, L, SD, NONE,        3'b000, 3'd3, L, L);
      step(OP_BEQ, H, H, L, SE, PCW,         3'b001, 3'd3, L, L);
      step(OP_BEQ, L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd4, L, L);
      step(OP_BEQ, L, H, L, SD, NONE,        3'b000, 3'd4, L, L);
      step(OP_BEQ, L, H, L, SE, NONE,        3'b001, 3'd4, L, L);
      step(OP_BNE, L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd5, L, L);
      step(OP_BNE, L, H, L, SD, NONE,        3'b000, 3'd5, L, L);
      step(OP_BNE, L, H, L, SE, PCW,         3'b001, 3'd5, L, L);
      // j, then jal which wraps the 3-bit retired counter from 7 to 0
      step(OP_J,   L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd6, L, L);
      step(OP_J,   L, H, L, SD, NONE,        3'b000, 3'd6, L, L);
      step(OP_J,   L, H, L, SE, PCW,         3'b000, 3'd6, L, L);
      step(OP_JAL, L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd7, L, L);
      step(OP_JAL, L, H, L, SD, NONE,        3'b000, 3'd7, L, L);
      step(OP_JAL, L, H, L, SE, PCW|RGW|LNK, 3'b000, 3'd7, L, L);
      // R-type
      step(OP_R, L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd0, L, L);
      step(OP_R, L, H, L, SD, NONE,        3'b000, 3'd0, L, L);
      step(OP_R, L, H, L, SE, NONE,        3'b111, 3'd0, L, L);
      step(OP_R, L, H, L, SW, RGW|RDST,    3'b111, 3'd0, L, L);
      // illegal opcode traps, stays trapped
      step(OP_BAD,  L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd1, L, L);
      step(OP_BAD,  L, H, L, SD, NONE,        3'b000, 3'd1, L, L);
      step(OP_BAD,  L, H, L, ST, NONE,        3'b000, 3'd1, H, L);
      step(OP_ADDI, L, H, L, ST, NONE,        3'b000, 3'd1, H, L);
      reset_pulse();

      // fetch timeout: four not-ready cycles trap
      step(OP_ADDI, L, L, L, SF, MRD,  3'b000, 3'd0, L, L);
      step(OP_ADDI, L, L, L, SF, MRD,  3'b000, 3'd0, L, L);
      step(OP_ADDI, L, L, L, SF, MRD,  3'b000, 3'd0, L, L);
      step(OP_ADDI, L, L, L, SF, MRD,  3'b000, 3'd0, L, L);
      step(OP_ADDI, L, L, L, ST, NONE, 3'b000, 3'd0, L, H);
      step(OP_ADDI, L, H, L, ST, NONE, 3'b000, 3'd0, L, H);
      reset_pulse();

      // ready on the fourth fetch cycle wins; then sw stalled five cycles in MEM
      step(OP_SW, L, L, L, SF, MRD,         3'b000, 3'd0, L, L);
      step(OP_SW, L, L, L, SF, MRD,         3'b000, 3'd0, L, L);
      step(OP_SW, L, L, L, SF, MRD,         3'b000, 3'd0, L, L);
      step(OP_SW, L, H, L, SF, PCW|IRW|MRD, 3'b000, 3'd0, L, L);
      step(OP_SW, L, H, L, SD, NONE,        3'b000, 3'd0, L, L);
      step(OP_SW, L, H, L, SE, ASRC,        3'b000, 3'd0, L, L);
      for (int i = 0; i < 5; i++)
         step(OP_SW, L, H, H, SM, IORD|ASRC, 3'b000, 3'd0, L, L);
      step(OP_SW, L, H, L, SM, IORD|MWR|ASRC, 3'b000, 3'd0, L, L);
      step(OP_SW, L, L, L, SF, MRD,           3'b000, 3'd1, L, L);

      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
